// File: rtl/tetris_board_renderer_pkg.sv
// Shared cell codes, palette and pipeline bundle
// types for the Tetris board renderer.
package tetris_board_renderer_pkg;

   typedef logic [2:0]  cell_t;
   typedef logic [23:0] rgb_t;

   localparam int DE = 2;
   localparam int VS = 1;
   localparam int HS = 0;

   localparam rgb_t PAL_EMPTY  = 24'h101010;
   localparam rgb_t PAL_I      = 24'h00FFFF;
   localparam rgb_t PAL_O      = 24'hFFFF00;
   localparam rgb_t PAL_T      = 24'hA000F0;
   localparam rgb_t PAL_S      = 24'h00F000;
   localparam rgb_t PAL_Z      = 24'hF00000;
   localparam rgb_t PAL_J      = 24'h0000F0;
   localparam rgb_t PAL_L      = 24'hF0A000;
   localparam rgb_t GRID_RGB   = 24'h303030;
   localparam rgb_t BORDER_RGB = 24'h808080;
   localparam rgb_t BLACK_RGB  = 24'h000000;

   typedef struct packed {
      logic [2:0] hve;
      logic       inb;
      logic       brd;
      logic       grid;
      logic       tick;
   } stage_t;

   function automatic rgb_t palette(cell_t c);
      rgb_t rgb;
      rgb = PAL_EMPTY;
      unique case (c)
         3'd0: rgb = PAL_EMPTY;
         3'd1: rgb = PAL_I;
         3'd2: rgb = PAL_O;
         3'd3: rgb = PAL_T;
         3'd4: rgb = PAL_S;
         3'd5: rgb = PAL_Z;
         3'd6: rgb = PAL_J;
         3'd7: rgb = PAL_L;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/tetris_board_renderer_cell_counter.sv
// Divider-free position counter: pixel-in-cell and
// cell index, presented for the current pixel.
module cell_counter
   import tetris_board_renderer_pkg::*;
#(
   parameter int CELL_SIZE = 32,
   parameter int IDX_W     = 4,
   parameter int PIX_W     = $clog2(CELL_SIZE + 1)
) (
   input  logic             i_pixel_clk,
   input  logic             i_rst,
   input  logic             load,
   input  logic             adv,
   output logic [PIX_W-1:0] pix,
   output logic [IDX_W-1:0] idx,
   output logic             wrap
);

   localparam logic [PIX_W-1:0] PIX_LAST =
      PIX_W'(CELL_SIZE - 1);

   logic [PIX_W-1:0] pix_q;
   logic [IDX_W-1:0] idx_q;

   assign wrap = adv && !load && (pix_q == PIX_LAST);

   always_comb begin
      pix = pix_q;
      idx = idx_q;
      if (load) begin
         pix = '0;
         idx = '0;
      end else if (wrap) begin
         pix = '0;
         idx = idx_q + 1'b1;
      end else if (adv) begin
         pix = pix_q + 1'b1;
      end
   end

   always_ff @(posedge i_pixel_clk) begin
      if (i_rst) begin
         pix_q <= '0;
         idx_q <= '0;
      end else begin
         pix_q <= pix;
         idx_q <= idx;
      end
   end

endmodule

// File: rtl/tetris_board_renderer.sv
// Raster-to-RGB stage: playfield lookup through an
// external board RAM, grid, border, sync delay.
module tetris_board_renderer
   import tetris_board_renderer_pkg::*;
#(
   parameter int H_RES     = 1280,
   parameter int V_RES     = 1024,
   parameter int CELL_SIZE = 32,
   parameter int BOARD_W   = 10,
   parameter int BOARD_H   = 20,
   parameter int ORIGIN_X  = 480,
   parameter int ORIGIN_Y  = 192,
   parameter int BORDER    = 4,
   parameter int ADDR_W    = 8
) (
   input  logic               i_pixel_clk,
   input  logic               i_rst,
   input  logic [2:0]         i_hve,
   input  logic signed [12:0] i_x,
   input  logic signed [12:0] i_y,
   output logic [ADDR_W-1:0]  o_cell_addr,
   output logic               o_cell_rd_en,
   input  logic [2:0]         i_cell_data,
   output logic [2:0]         o_hve,
   output logic [23:0]        o_rgb,
   output logic               o_frame_tick
);

   localparam int BW_PX = BOARD_W * CELL_SIZE;
   localparam int BH_PX = BOARD_H * CELL_SIZE;
   localparam int CX_W  = $clog2(BOARD_W + 1);
   localparam int RY_W  = $clog2(BOARD_H + 1);
   localparam int PX_W  = $clog2(CELL_SIZE + 1);

   typedef logic signed [12:0] coord_t;

   localparam coord_t X_LO  = coord_t'(ORIGIN_X);
   localparam coord_t X_HI  = coord_t'(ORIGIN_X + BW_PX);
   localparam coord_t Y_LO  = coord_t'(ORIGIN_Y);
   localparam coord_t Y_HI  = coord_t'(ORIGIN_Y + BH_PX);
   localparam coord_t BX_LO = coord_t'(ORIGIN_X - BORDER);
   localparam coord_t BX_HI =
      coord_t'(ORIGIN_X + BW_PX + BORDER);
   localparam coord_t BY_LO = coord_t'(ORIGIN_Y - BORDER);
   localparam coord_t BY_HI =
      coord_t'(ORIGIN_Y + BH_PX + BORDER);
   localparam coord_t X_LAST = coord_t'(H_RES - 1);
   localparam coord_t Y_LAST = coord_t'(V_RES - 1);

   logic x_org, y_org, x_in, y_in, bx_in, by_in;
   logic col_load, col_adv, row_load, row_adv;
   logic col_wrap, row_wrap;
   logic [PX_W-1:0] px, py;
   logic [CX_W-1:0] cx;
   logic [RY_W-1:0] ry;
   logic [ADDR_W-1:0] row_base, row_base_q;
   logic row_sync, row_sync_q;
   logic in_board, border, grid, tick;
   stage_t s1, s2;
   rgb_t rgb_c;

   assign x_org = (i_x == X_LO);
   assign y_org = (i_y == Y_LO);
   assign x_in  = (i_x >= X_LO) && (i_x < X_HI);
   assign y_in  = (i_y >= Y_LO) && (i_y < Y_HI);
   assign bx_in = (i_x >= BX_LO) && (i_x < BX_HI);
   assign by_in = (i_y >= BY_LO) && (i_y < BY_HI);

   assign col_load = x_org;
   assign col_adv  = x_in && !x_org;
   assign row_load = x_org && y_org;
   assign row_adv  = x_org && y_in && !y_org;

   cell_counter #(
      .CELL_SIZE (CELL_SIZE),
      .IDX_W     (CX_W)
   ) u_col (
      .i_pixel_clk (i_pixel_clk),
      .i_rst       (i_rst),
      .load        (col_load),
      .adv         (col_adv),
      .pix         (px),
      .idx         (cx),
      .wrap        (col_wrap)
   );

   cell_counter #(
      .CELL_SIZE (CELL_SIZE),
      .IDX_W     (RY_W)
   ) u_row (
      .i_pixel_clk (i_pixel_clk),
      .i_rst       (i_rst),
      .load        (row_load),
      .adv         (row_adv),
      .pix         (py),
      .idx         (ry),
      .wrap        (row_wrap)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, col_wrap};

   always_comb begin
      row_base = row_base_q;
      if (row_load)
         row_base = '0;
      else if (row_wrap)
         row_base = row_base_q + ADDR_W'(BOARD_W);
   end

   // No board reads until a full frame top has been seen.
   assign row_sync = row_sync_q | row_load;

   assign in_board = i_hve[DE] && row_sync
                  && x_in && y_in
                  && (cx < CX_W'(BOARD_W))
                  && (ry < RY_W'(BOARD_H));
   assign border = i_hve[DE] && bx_in && by_in
                && !(x_in && y_in);
   assign grid = (px == '0) || (py == '0);
   assign tick = (i_x == X_LAST) && (i_y == Y_LAST);

   always_comb begin
      rgb_c = BLACK_RGB;
      unique case (1'b1)
         s2.inb:
            rgb_c = (i_cell_data == 3'd0 && s2.grid)
                  ? GRID_RGB : palette(i_cell_data);
         s2.brd:
            rgb_c = BORDER_RGB;
         default:
            rgb_c = BLACK_RGB;
      endcase
   end

   always_ff @(posedge i_pixel_clk) begin
      if (i_rst) begin
         row_base_q   <= '0;
         row_sync_q   <= 1'b0;
         o_cell_addr  <= '0;
         o_cell_rd_en <= 1'b0;
         s1           <= '0;
         s2           <= '0;
         o_hve        <= '0;
         o_rgb        <= '0;
         o_frame_tick <= 1'b0;
      end else begin
         row_base_q   <= row_base;
         row_sync_q   <= row_sync;
         o_cell_rd_en <= in_board;
         if (in_board)
            o_cell_addr <= row_base + ADDR_W'(cx);
         s1.hve       <= i_hve;
         s1.inb       <= in_board;
         s1.brd       <= border;
         s1.grid      <= grid;
         s1.tick      <= tick;
         s2           <= s1;
         o_hve        <= s2.hve;
         o_rgb        <= rgb_c;
         o_frame_tick <= s2.tick;
      end
   end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Directed raster bench for tetris_board_renderer with
// a coordinate-arithmetic reference model.
module tb_tetris_board_renderer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [2:0]         hve;
   logic signed [12:0] x, y;
   logic [7:0]         addr;
   logic               rd;
   logic [2:0]         cdata;
   logic [2:0]         ohve;
   logic [23:0]        rgb;
   logic               tick;

   tetris_board_renderer dut (
      .i_pixel_clk  (clk),
      .i_rst        (rst),
      .i_hve        (hve),
      .i_x          (x),
      .i_y          (y),
      .o_cell_addr  (addr),
      .o_cell_rd_en (rd),
      .i_cell_data  (cdata),
      .o_hve        (ohve),
      .o_rgb        (rgb),
      .o_frame_tick (tick)
   );

   logic [2:0] mem [256];
   logic [2:0] ram_q;
   always_ff @(posedge clk) if (rd) ram_q <= mem[addr];
   assign cdata = ram_q;

   logic [23:0] pal [8];
   int vectors = 0;
   int errors  = 0;
   int cyc     = -1;

   logic [2:0]  e_hve  [8];
   logic [23:0] e_rgb  [8];
   bit          e_tick [8];
   bit          e_rd   [8];
   int          e_addr [8];
   logic [23:0] lit_rgb  [int];
   int          lit_addr [int];

   bit rs;
   int rst_left, phase;
   int rd_cnt0, tick_cnt1, first_rd, org_cyc;
   int last_cyc, tick_cyc;

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h want %0h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic set_lit(int px_, int py_);
      if (px_ == 480 && py_ == 192) begin
         lit_rgb[cyc] = 24'h00FFFF; lit_addr[cyc] = 0;
      end
      if (px_ == 799 && py_ == 831) begin
         lit_rgb[cyc] = 24'hF0A000; lit_addr[cyc] = 199;
      end
      if (px_ == 512 && py_ == 200) begin
         lit_rgb[cyc] = 24'h303030; lit_addr[cyc] = 1;
      end
      if (px_ == 513 && py_ == 200) begin
         lit_rgb[cyc] = 24'h101010; lit_addr[cyc] = 1;
      end
      if (px_ == 476 && py_ == 192) lit_rgb[cyc] = 24'h808080;
      if (px_ == 475 && py_ == 192) lit_rgb[cyc] = 24'h000000;
      if (px_ == 800 && py_ == 832) lit_rgb[cyc] = 24'h808080;
      if (px_ == 600 && py_ == 201) lit_rgb[cyc] = 24'h000000;
   endtask

   task automatic drive(int px_, int py_, bit de, bit vs, bit hs);
      int k, a;
      bit inr, inb, brd;
      logic [23:0] c;
      @(posedge clk); #1;
      cyc++;
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      hve = {de, vs, hs};
      x = 13'(px_);
      y = 13'(py_);
      k = cyc & 7;
      if (rst) begin
         rs = 0;
         e_rd[k] = 0;
         e_addr[k] = 0;
         for (int j = 0; j < 3; j++) begin
            e_hve[(cyc - j) & 7]  = '0;
            e_rgb[(cyc - j) & 7]  = '0;
            e_tick[(cyc - j) & 7] = 0;
         end
      end else begin
         if (px_ == 480 && py_ == 192) rs = 1;
         inr = px_ >= 480 && px_ < 800 && py_ >= 192 && py_ < 832;
         inb = de && rs && inr;
         brd = de && !inr && px_ >= 476 && px_ < 804
            && py_ >= 188 && py_ < 836;
         a = ((py_ - 192) / 32) * 10 + (px_ - 480) / 32;
         c = 24'h000000;
         if (inb) begin
            if (mem[a] == 0 && ((px_ - 480) % 32 == 0
                || (py_ - 192) % 32 == 0))
               c = 24'h303030;
            else
               c = pal[mem[a]];
         end else if (brd) begin
            c = 24'h808080;
         end
         e_hve[k]  = {de, vs, hs};
         e_rgb[k]  = c;
         e_tick[k] = (px_ == 1279 && py_ == 1023);
         e_rd[k]   = inb;
         e_addr[k] = inb ? a : 0;
         if (phase == 1) begin
            set_lit(px_, py_);
            if (inb && org_cyc < 0) org_cyc = cyc;
            if (e_tick[k]) last_cyc = cyc;
         end
      end
   endtask

   task automatic line(int yy, bit full);
      drive(-10, yy, 0, 0, 1);
      if (full) begin
         for (int xx = 470; xx <= 810; xx++)
            drive(xx, yy, !(yy == 201 && xx >= 600 && xx < 605),
                  0, 0);
      end else begin
         for (int xx = 470; xx <= 482; xx++)
            drive(xx, yy, 1, 0, 0);
         if (yy < 192 || yy >= 832)
            for (int xx = 795; xx <= 805; xx++)
               drive(xx, yy, 1, 0, 0);
      end
      drive(1279, yy, 1, 0, 0);
   endtask

   task automatic vblank();
      for (int i = 0; i < 6; i++) drive(-10, -2, 0, 1, 0);
   endtask

   always @(negedge clk) begin
      int k1, k3;
      if (cyc >= 1) begin
         k1 = (cyc - 1) & 7;
         k3 = (cyc - 3) & 7;
         chk("hve", int'(ohve), int'(e_hve[k3]));
         chk("rgb", int'(rgb), int'(e_rgb[k3]));
         chk("tick", int'(tick), int'(e_tick[k3]));
         chk("rd_en", int'(rd), int'(e_rd[k1]));
         if (e_rd[k1]) chk("addr", int'(addr), e_addr[k1]);
         if (lit_rgb.exists(cyc - 3))
            chk("lit_rgb", int'(rgb), int'(lit_rgb[cyc - 3]));
         if (lit_addr.exists(cyc - 1))
            chk("lit_addr", int'(addr), lit_addr[cyc - 1]);
         if (phase == 0 && rd) rd_cnt0++;
         if (phase == 1 && rd && first_rd < 0) first_rd = cyc;
         if (phase == 1 && tick) begin
            tick_cnt1++;
            tick_cyc = cyc;
         end
      end
   end

   initial begin
      pal = '{24'h101010, 24'h00FFFF, 24'hFFFF00, 24'hA000F0,
              24'h00F000, 24'hF00000, 24'h0000F0, 24'hF0A000};
      for (int i = 0; i < 256; i++) mem[i] = 3'((i * 5 + 3) % 8);
      mem[0] = 3'd1;
      mem[1] = 3'd0;
      mem[199] = 3'd7;
      for (int i = 0; i < 8; i++) begin
         e_hve[i] = '0; e_rgb[i] = '0; e_tick[i] = 0;
         e_rd[i] = 0; e_addr[i] = 0;
      end
      rs = 0; phase = 0; rst_left = 5;
      rd_cnt0 = 0; tick_cnt1 = 0;
      first_rd = -1; org_cyc = -1;
      last_cyc = -1; tick_cyc = -1;
      rst = 1'b1; hve = '0; x = '0; y = '0;

      for (int yy = 300; yy < 1024; yy++) line(yy, yy == 831);
      vblank();
      phase = 1;
      for (int yy = 0; yy < 1024; yy++)
         line(yy, yy == 192 || yy == 200 || yy == 201
               || yy == 223 || yy == 224 || yy == 831);
      vblank();

      chk("rd_before_sync", rd_cnt0, 0);
      chk("first_rd_cyc", first_rd, org_cyc + 1);
      chk("ticks_frame1", tick_cnt1, 1);
      chk("tick_cyc", tick_cyc, last_cyc + 3);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/tetris_board_renderer.md
Name: tetris_board_renderer

Overview:
- Pixel-pipeline stage directly downstream of the raster timing generator. Consumes its {display_enable, vsync, hsync} bundle and signed 13-bit x/y coordinates.
- Maps each visible pixel onto the Tetris playfield grid, reads the cell colour code from an external board RAM, and produces 24-bit RGB.
- Delays the sync bundle so it stays aligned with the pixels feeding the HDMI encoder.
- Raises a once-per-frame tick at the start of vertical blanking so game logic can update the board RAM safely.

Parameters:
- H_RES, 1280, visible width in pixels
- V_RES, 1024, visible height in lines
- CELL_SIZE, 32, cell edge in pixels (power of two not required)
- BOARD_W, 10, playfield columns
- BOARD_H, 20, playfield rows
- ORIGIN_X, 480, x of the playfield's top-left pixel
- ORIGIN_Y, 192, y of the playfield's top-left pixel
- BORDER, 4, frame thickness in pixels drawn outside the playfield
- ADDR_W, 8, board RAM address width (must satisfy 2^ADDR_W >= BOARD_W*BOARD_H)

Ports:
- i_pixel_clk  in  1  pixel clock; the only clock
- i_rst  in  1  synchronous, active-high reset
- i_hve  in  3  {display_enable, vsync, hsync} from the timing generator
- i_x  in  13 signed  pixel x; negative in blanking
- i_y  in  13 signed  pixel y; negative in blanking
- o_cell_addr  out  ADDR_W  board RAM read address, row*BOARD_W+col
- o_cell_rd_en  out  1  read strobe; high only for in-board pixels
- i_cell_data  in  3  cell code from RAM, valid exactly 1 cycle after o_cell_rd_en
- o_hve  out  3  i_hve delayed by 3 cycles
- o_rgb  out  24  {R,G,B} aligned with o_hve
- o_frame_tick  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Interface: single clock domain on i_pixel_clk. i_rst is synchronous and active-high.
- Reset: all outputs are 0, pipeline registers are 0, counters are 0, and row_sync is 0.
- Latency: fixed at 3 cycles from i_hve/i_x/i_y to o_hve/o_rgb, with no bubbles. Pipeline stages:
  - S0: counter update and region classification.
  - S1: address issue.
  - S2: RAM data return.
  - S3: palette, grid and border lookup, registered into o_rgb.
- Column counters (cx, px) avoid any divider:
  - At i_x==ORIGIN_X: cx<=0, px<=0.
  - Otherwise, while inside the board span: px increments; when px==CELL_SIZE-1, px wraps to 0 and cx increments.
- Row counters (ry, py, row_base) advance once per line at i_x==ORIGIN_X:
  - At i_y==ORIGIN_Y: ry<=0, py<=0, row_base<=0, row_sync<=1.
  - Otherwise: py increments; on wrap, ry increments and row_base+=BOARD_W.
  - All signed comparisons use 13-bit operands.
- in_board = display_enable && row_sync && ORIGIN_X<=x<ORIGIN_X+BOARD_W*CELL_SIZE && ORIGIN_Y<=y<ORIGIN_Y+BOARD_H*CELL_SIZE.
- Address and read strobe: o_cell_addr = row_base+cx, and o_cell_rd_en = in_board; both registered in S1. When not in_board, o_cell_rd_en=0 and o_cell_addr holds its previous value.
- Palette for cell codes:
  - 0: 0x101010
  - 1: 0x00FFFF
  - 2: 0xFFFF00
  - 3: 0xA000F0
  - 4: 0x00F000
  - 5: 0xF00000
  - 6: 0x0000F0
  - 7: 0xF0A000
- Grid lines: an empty cell (code 0) with px==0 or py==0 renders 0x303030. Filled cells render their solid palette colour.
- Border: a pixel that is not in_board but lies within BORDER pixels outside the playfield rectangle renders 0x808080. Corners are included.
- Black: any other visible pixel renders 0x000000. When delayed display_enable is 0, o_rgb is 0x000000.
- Frame tick: o_frame_tick pulses for one cycle when the S0 pixel is (H_RES-1, V_RES-1), delayed 3 cycles. It fires once per frame and never during reset.
- Reset released mid-frame: row_sync stays 0, so no board pixels or reads occur until the next ORIGIN_Y line. Border and black rendering and hve alignment resume immediately after the 3-cycle fill.
- Simultaneous events: a row wrap and a column reset on the same cycle are both applied. i_cell_data is sampled only on cycles following o_cell_rd_en.

Decomposition:
- A shared package holds the palette constants (PAL_EMPTY, PAL_I..PAL_L, GRID_RGB, BORDER_RGB), the cell-code typedef (3-bit), and the hve bit indices (DE=2, VS=1, HS=0).
- One sub-module, cell_counter, is natural. It is instantiated twice, once for columns and once for rows. It takes a load strobe and an advance strobe, and outputs the pixel-in-cell count, the cell index, and a wrap pulse.

Test Plan:
- Reset held 5 cycles mid-line, then released → o_rgb=0, o_hve=0, o_cell_rd_en=0 during reset; o_hve follows i_hve exactly 3 cycles later.
- Pixel (480,192) with RAM cell 0 = code 1 → o_cell_addr=0 with rd_en one cycle after input; o_rgb=0x00FFFF 3 cycles after input.
- Pixel (799,831) (cell col 9, row 19) with code 7 → o_cell_addr=199; o_rgb=0xF0A000.
- Pixel (512,200) with an empty cell → grid 0x303030; pixel (513,200) → 0x101010.
- Pixels (476,192) and (800,832) → 0x808080; (475,192) → 0x000000; display_enable=0 anywhere → 0x000000.
- Full 1280x1024 frame → exactly one o_frame_tick, 3 cycles after pixel (1279,1023); reset released at y=300 → no rd_en until the next frame's y=192.
